// File: rtl/serial_pkg.sv
// serial_pkg: shared line levels and transmit FSM states for the single-wire serial link.
// Rev 1.0
`default_nettype none

package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// bit_timer: counts clock cycles within one serial bit; tick marks the last cycle of the bit.
// Rev 1.0
`default_nettype none

module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = run && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in/serial-out transmitter (start 0, data LSB first, stop 1).
// Rev 1.0
`default_nettype none

module piso_serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              w_tx_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic              w_tick;
  logic              w_run;
  logic              w_accept;
  logic              w_last_bit;

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_last_bit = (r_idx == c_IDX_LAST);
  assign w_run      = (r_state != IDLE);

  assign tx_out = r_tx;
  assign busy   = r_busy;
  assign done   = r_done;

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)               w_state_next = START;
      START:   if (w_tick)                 w_state_next = DATA;
      DATA:    if (w_tick && w_last_bit)   w_state_next = STOP;
      STOP:    if (w_tick)                 w_state_next = IDLE;
      default:                             w_state_next = IDLE;
    endcase
  end

  // The line shows the LSB of the shift register during DATA, so shifting happens only on DATA ticks.
  always_comb begin
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_next = in_data;
          w_idx_next   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          w_idx_next   = w_last_bit ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
      end
    endcase

    case (w_state_next)
      START:   w_tx_next = START_BIT;
      DATA:    w_tx_next = w_shift_next[0];
      STOP:    w_tx_next = STOP_BIT;
      default: w_tx_next = IDLE_LEVEL;
    endcase

    w_busy_next = (w_state_next != IDLE);
    w_done_next = (r_state == STOP) && w_tick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

endmodule

`default_nettype wire
